// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol path:
// element encoding, symbol FSM states, default symbol length.
package morse_pkg;

  localparam int MAX_LEN_DEF = 5;

  localparam logic ELEM_DOT  = 1'b0;
  localparam logic ELEM_DASH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_EMIT,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/morse_gap_timer.sv
// Inter-character gap timer: counts idle cycles and flags the
// cycle on which the gap reaches GAP_CYCLES. Saturates, never wraps.
module morse_gap_timer #(
  parameter int GAP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(GAP_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(GAP_CYCLES);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && cnt_q != LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/morse_symbol_ctrl.sv
// Collects debounced dot/dash/enter pulses into Morse symbols and
// hands each one to the decoder over a valid/ready handshake.
module morse_symbol_ctrl
  import morse_pkg::*;
#(
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int GAP_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dot_pulse,
  input  logic               dash_pulse,
  input  logic               enter_pulse,
  input  logic               sym_ready,
  output logic               sym_valid,
  output logic [MAX_LEN-1:0] sym_pattern,
  output logic [2:0]         sym_len,
  output logic               overflow_err,
  output logic               drop_pulse,
  output logic               busy
);

  typedef logic [MAX_LEN-1:0] pat_t;

  state_e     state_q, state_d;
  pat_t       pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic       drop_q, drop_d;
  logic       valid_q, err_q, busy_q;

  logic one_el, both_el, any_p, full, expired, collecting;
  pat_t el_bit;

  assign both_el    = dot_pulse && dash_pulse;
  assign one_el     = dot_pulse ^ dash_pulse;
  assign any_p      = dot_pulse || dash_pulse || enter_pulse;
  assign full       = (len_q == 3'(MAX_LEN));
  assign collecting = (state_q == ST_COLLECT);
  assign el_bit     = pat_t'(dash_pulse ? ELEM_DASH : ELEM_DOT) << len_q;

  morse_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (!collecting || any_p),
    .en_i     (collecting && !any_p),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        drop_d = both_el;
        // overflow takes priority over a same-cycle commit
        if (one_el && full) begin
          state_d = ST_ERROR;
        end else begin
          if (one_el) begin
            pat_d   = pat_q | el_bit;
            len_d   = len_q + 3'd1;
            state_d = ST_COLLECT;
          end
          if (enter_pulse || expired) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        drop_d = any_p;
        if (sym_ready) begin
          state_d = ST_IDLE;
          pat_d   = '0;
          len_d   = '0;
        end
      end
      ST_ERROR: begin
        drop_d = dot_pulse || dash_pulse;
        if (enter_pulse) begin
          state_d = ST_IDLE;
          pat_d   = '0;
          len_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      drop_q  <= drop_d;
      valid_q <= (state_d == ST_EMIT);
      err_q   <= (state_d == ST_ERROR);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign sym_valid    = valid_q;
  assign sym_pattern  = pat_q;
  assign sym_len      = len_q;
  assign overflow_err = err_q;
  assign drop_pulse   = drop_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_morse_symbol_ctrl.sv
// Directed and random checks of morse_symbol_ctrl against a
// queue-based reference model.
module tb_morse_symbol_ctrl;

  localparam int GAP  = 20;
  localparam int MAXL = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dot_pulse = 1'b0;
  logic       dash_pulse = 1'b0;
  logic       enter_pulse = 1'b0;
  logic       sym_ready = 1'b1;
  logic       sym_valid;
  logic [4:0] sym_pattern;
  logic [2:0] sym_len;
  logic       overflow_err;
  logic       drop_pulse;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  bit q[$];
  bit m_emit, m_err, m_drop;
  int gap;

  morse_symbol_ctrl #(
    .MAX_LEN   (MAXL),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dot_pulse   (dot_pulse),
    .dash_pulse  (dash_pulse),
    .enter_pulse (enter_pulse),
    .sym_ready   (sym_ready),
    .sym_valid   (sym_valid),
    .sym_pattern (sym_pattern),
    .sym_len     (sym_len),
    .overflow_err(overflow_err),
    .drop_pulse  (drop_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] mpat();
    logic [4:0] p = '0;
    foreach (q[i]) p[i] = q[i];
    return p;
  endfunction

  // One clock of the reference behaviour, expressed on the element queue.
  task automatic model_step(input bit d, input bit da, input bit e,
                            input bit r, input bit rdy);
    bit collecting;
    bit commit;
    if (r) begin
      q.delete();
      m_emit = 0; m_err = 0; m_drop = 0; gap = 0;
      return;
    end
    m_drop = 0;
    if (m_emit) begin
      m_drop = d | da | e;
      gap = 0;
      if (rdy) begin m_emit = 0; q.delete(); end
    end else if (m_err) begin
      m_drop = d | da;
      gap = 0;
      if (e) begin m_err = 0; q.delete(); end
    end else begin
      collecting = q.size() > 0;
      commit = 0;
      if (d && da) m_drop = 1;
      else if (d || da) begin
        if (q.size() == MAXL) m_err = 1;
        else q.push_back(da);
      end
      if (!m_err) begin
        if (e) commit = 1;
        else if (collecting && !d && !da) begin
          if (gap == GAP) commit = 1;
          else gap++;
        end else gap = 0;
      end
      if (commit) begin m_emit = 1; gap = 0; end
    end
  endtask

  task automatic check_all();
    chk("valid",    32'(sym_valid),    32'(m_emit));
    chk("pattern",  32'(sym_pattern),  32'(mpat()));
    chk("len",      32'(sym_len),      q.size());
    chk("overflow", 32'(overflow_err), 32'(m_err));
    chk("drop",     32'(drop_pulse),   32'(m_drop));
    chk("busy",     32'(busy),         32'(m_emit | m_err | (q.size() > 0)));
  endtask

  task automatic cyc(input bit d, input bit da, input bit e, input bit r);
    dot_pulse = d; dash_pulse = da; enter_pulse = e; rst = r;
    @(posedge clk);
    model_step(d, da, e, r, sym_ready);
    #1;
    check_all();
    dot_pulse = 0; dash_pulse = 0; enter_pulse = 0; rst = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int n;
    int thr;
    thr = 10;
    // reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_valid", 32'(sym_valid), 0);
    chk("rst_len",   32'(sym_len),   0);
    chk("rst_busy",  32'(busy),      0);

    // dot dash dot dot, enter with ready high
    sym_ready = 1;
    cyc(1, 0, 0, 0); idle(3);
    cyc(0, 1, 0, 0); idle(3);
    cyc(1, 0, 0, 0); idle(3);
    cyc(1, 0, 0, 0); idle(3);
    cyc(0, 0, 1, 0);
    chk("s1_valid", 32'(sym_valid),   1);
    chk("s1_pat",   32'(sym_pattern), 'h02);
    chk("s1_len",   32'(sym_len),     4);
    idle(1);
    chk("s1_vlow",  32'(sym_valid),   0);

    // dash then idle: auto-commit after the gap
    cyc(0, 1, 0, 0);
    n = 0;
    while (!sym_valid && n < 40) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    chk("s2_latency", n, GAP + 1);
    chk("s2_pat", 32'(sym_pattern), 'h01);
    chk("s2_len", 32'(sym_len), 1);
    idle(2);

    // overflow, dropped dot, enter clears
    repeat (5) cyc(1, 0, 0, 0);
    chk("s3_noerr", 32'(overflow_err), 0);
    cyc(1, 0, 0, 0);
    chk("s3_err",   32'(overflow_err), 1);
    chk("s3_nov",   32'(sym_valid),    0);
    chk("s3_len",   32'(sym_len),      5);
    cyc(1, 0, 0, 0);
    chk("s3_drop",  32'(drop_pulse),   1);
    cyc(0, 0, 1, 0);
    chk("s3_clr",   32'(overflow_err), 0);
    chk("s3_nov2",  32'(sym_valid),    0);
    chk("s3_idle",  32'(busy),         0);
    idle(2);

    // word space held while decoder stalls, dot dropped meanwhile
    sym_ready = 0;
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      cyc(i == 4, 0, 0, 0);
      chk("s4_valid", 32'(sym_valid), 1);
      chk("s4_len",   32'(sym_len),   0);
      if (i == 4) chk("s4_drop", 32'(drop_pulse), 1);
    end
    sym_ready = 1;
    cyc(0, 0, 0, 0);
    chk("s4_vlow", 32'(sym_valid), 0);

    // simultaneous dot&dash, then dash+enter together
    cyc(1, 1, 0, 0);
    chk("s5_drop", 32'(drop_pulse), 1);
    chk("s5_len",  32'(sym_len),    0);
    cyc(0, 1, 1, 0);
    chk("s5_valid", 32'(sym_valid),   1);
    chk("s5_pat",   32'(sym_pattern), 'h01);
    chk("s5_len1",  32'(sym_len),     1);
    chk("s5_nodrp", 32'(drop_pulse),  0);
    idle(2);

    // reset mid-collect and mid-emit
    cyc(1, 0, 0, 0); idle(1);
    cyc(0, 1, 0, 0); idle(1);
    cyc(1, 0, 0, 0);
    chk("s6_len3", 32'(sym_len), 3);
    cyc(0, 0, 0, 1);
    chk("s6_len0", 32'(sym_len),     0);
    chk("s6_pat0", 32'(sym_pattern), 0);
    chk("s6_busy", 32'(busy),        0);
    cyc(1, 0, 0, 0);
    chk("s6_len1", 32'(sym_len), 1);
    sym_ready = 0;
    cyc(0, 0, 1, 0);
    chk("s6_emit", 32'(sym_valid), 1);
    cyc(0, 0, 0, 1);
    chk("s6_vrst", 32'(sym_valid), 0);
    chk("s6_lrst", 32'(sym_len),   0);
    sym_ready = 1;

    // random traffic with varying pulse density
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) thr = $urandom_range(2, 30);
      sym_ready = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 99) < thr,
          $urandom_range(0, 99) < thr,
          $urandom_range(0, 99) < thr / 3,
          $urandom_range(0, 499) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
